// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
//
// Bundles the display-driver signals between the CPU debug side and the
// board pins. The master side supplies the value to show. The slave side is
// the scan driver, and it returns the multiplexed pin levels.
//
//   value      [4*NUM_DIGITS] hex nibbles, nibble 0 is the rightmost digit
//   dp_in      [NUM_DIGITS]   decimal-point request per digit
//   load       [1]            captures value/dp_in into the pending image
//   lz_en      [1]            leading-zero blanking enable (sampled live)
//   seg        [7]            shared segment lines {g,f,e,d,c,b,a}
//   dp         [1]            decimal point of the digit being scanned
//   an         [NUM_DIGITS]   per-digit enables
//   frame_done [1]            one-cycle pulse after each complete scan
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    lz_en;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output value, dp_in, load, lz_en,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value, dp_in, load, lz_en,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed hex display driver. One shared hex-to-7-segment decoder
// serves all digits. A divider and a digit index step through the digit
// slots. The first BLANK_CYCLES of each slot keep every enable off, so the
// previous digit's segments do not ghost onto the next digit.
//
// New values are captured into a pending image on load. They move into the
// active image only at a frame boundary, so one scan never mixes two loads.
//
//   clk             system clock
//   rst             synchronous, active-high reset
//   bus (slave)     value/dp_in/load/lz_en in; seg/dp/an/frame_done out
//
// All outputs are registered. They follow div/idx with one cycle of latency.
// NUM_DIGITS must be >= 2, SCAN_DIV must be >= 2, and BLANK_CYCLES must be
// < SCAN_DIV.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 1,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // The output stage XORs every pin with POL. Internal logic therefore
    // works in active-high terms regardless of board polarity.
    localparam logic                  POL     = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF = {7{POL}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

    // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h67;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h58;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Scan position
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Displayed image and the image waiting for the next frame boundary
    logic [VAL_W-1:0]      act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [VAL_W-1:0]      pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_v_q, pend_v_d;

    // Registered pin levels
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    // Output-stage intermediates
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  zeros_above;
    logic [NUM_DIGITS-1:0] an_hi;
    logic [6:0]            seg_hi;

    logic slot_end;
    logic frame_end;

    assign slot_end  = (div_q == DIV_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // -------------------------------------------------------------------------
    // Divider and digit index
    // -------------------------------------------------------------------------
    always_comb begin : scan_next
        // NOTE: every variable written in an always_comb gets a default value
        // first. A path that leaves a variable unassigned would infer a latch.
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            div_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Pending and active images
    // -------------------------------------------------------------------------
    // The boundary transfer reads pend_*_q. A load in the boundary cycle
    // therefore moves the earlier capture to the display, and the new capture
    // waits (with pend_v set) for the following frame.
    always_comb begin : image_next
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_v_d   = pend_v_q;

        if (frame_end && pend_v_q) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
            pend_v_d  = 1'b0;
        end

        // A load overrides the clear above, and the last load wins.
        if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp_in;
            pend_v_d   = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output stage: digit select, leading-zero blanking, decode, polarity
    // -------------------------------------------------------------------------
    // The scan runs from the most significant nibble downward. zeros_above is
    // set only while every nibble from i up to the top is zero. Digit 0 is
    // excluded, so an all-zero value still shows "0".
    always_comb begin : out_next
        cur_nib     = 4'h0;
        cur_dp      = 1'b0;
        cur_blank   = 1'b0;
        zeros_above = 1'b1;
        an_hi       = '0;

        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeros_above = zeros_above && (act_val_q[i*4 +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = act_val_q[i*4 +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = zeros_above && (i != 0);
                an_hi[i]  = 1'b1;
            end
        end

        // A blanked digit keeps its enable on and its dp. Only the segments
        // go dark.
        seg_hi = (bus.lz_en && cur_blank) ? 7'h00 : hex_decode(cur_nib);

        // Anti-ghosting: all enables stay off at the start of each slot.
        if (div_q < BLANK_END) begin
            an_hi = '0;
        end

        an_d         = an_hi ^ AN_OFF;
        seg_d        = seg_hi ^ SEG_OFF;
        dp_d         = cur_dp ^ POL;
        frame_done_d = frame_end;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            // NOTE: the image registers are reset as well as the control
            // state. After reset the display must show zeros, and any pending
            // update must be discarded.
            act_val_q    <= '0;
            act_dp_q     <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_v_q     <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= POL;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the values that were present before the edge. This keeps the
            // update independent of statement order.
            div_q        <= div_d;
            idx_q        <= idx_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_v_q     <= pend_v_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule
